// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: sequences one anneal (reset hold, free run, majority phase sample) and
// blocks weight writes into the array while the oscillators are live.
module ising_run_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 31,
  parameter int SYNC_STAGES   = 2
) (
  input  logic         clk,
  input  logic         axi_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [15:0]  rst_cycles,
  input  logic [31:0]  run_cycles,
  input  logic [N-1:0] spin_in,
  input  logic         wready_in,
  output logic         wready_out,
  output logic         wr_allow,
  output logic         ising_rstn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         result_valid
);
  localparam int VW = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [VW-1:0] HALF = VW'(SAMPLE_CYCLES / 2);
  typedef enum logic [2:0] {IDLE, RESET, RUN, SAMPLE, DONE} state_t;
  state_t state, next_state;
  logic [31:0] cnt, run_len;
  logic [15:0] rst_len;
  logic [32:0] cnt_inc;
  logic accept, last, enter_done;
  logic [N-1:0] sync [SYNC_STAGES];
  logic [N-1:0] in_ph, res_nxt;
  logic [VW-1:0] vote [N];
  logic [VW-1:0] vote_nxt [N];

  assign busy = state == RESET || state == RUN || state == SAMPLE;
  assign wr_allow = !busy;
  assign wready_out = wready_in & wr_allow;
  assign cnt_inc = {1'b0, cnt} + 33'd1;
  assign accept = start && !abort && (state == IDLE || state == DONE);
  assign in_ph = sync[SYNC_STAGES-1] ~^ {N{sync[SYNC_STAGES-1][0]}};
  assign enter_done = next_state == DONE && state != DONE;

  // a zero reset/run length still spends one cycle in its state
  always_comb begin
    last = state == RESET ? cnt_inc >= {17'd0, rst_len} :
           state == RUN   ? cnt_inc >= {1'b0, run_len} :
                            cnt_inc >= 33'(SAMPLE_CYCLES);
    next_state = abort             ? IDLE   :
                 accept            ? RESET  :
                 !last             ? state  :
                 state == RESET    ? RUN    :
                 state == RUN      ? SAMPLE :
                 state == SAMPLE   ? DONE   : state;
  end

  always_comb begin
    res_nxt = '0;
    for (int k = 0; k < N; k++) begin
      vote_nxt[k] = vote[k] + VW'(in_ph[k]);
      res_nxt[k] = vote_nxt[k] > HALF;
    end
    res_nxt[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rst_len      <= '0;
      run_len      <= '0;
      ising_rstn   <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
      for (int k = 0; k < N; k++) vote[k] <= '0;
    end else begin
      state        <= next_state;
      cnt          <= (next_state != state || !busy) ? '0 : cnt_inc[31:0];
      ising_rstn   <= !abort && (state == RUN || state == SAMPLE);
      done         <= enter_done;
      result_valid <= next_state == DONE;
      if (accept) begin
        rst_len <= rst_cycles;
        run_len <= run_cycles;
      end
      if (enter_done) result <= res_nxt;
      sync[0] <= spin_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
      for (int k = 0; k < N; k++) vote[k] <= state == SAMPLE ? vote_nxt[k] : '0;
    end
  end
endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb_ising_run_ctrl: randomized scoreboard bench; expectations come from a per-anneal timeline
// and a majority count over the planned spin window.
module tb_ising_run_ctrl;
  localparam int N = 8, S = 31, SS = 2;
  logic clk = 0, axi_rst = 1, start = 0, abort = 0, wready_in = 0;
  logic [15:0] rst_cycles = 0;
  logic [31:0] run_cycles = 0;
  logic [N-1:0] spin_in = 0;
  logic [N-1:0] result;
  logic wready_out, wr_allow, ising_rstn, busy, done, result_valid;
  typedef struct { int at; logic [N-1:0] res; } exp_t;
  exp_t sb[$];
  logic [N-1:0] plan[$];
  logic [N-1:0] last_res = 0;
  int cyc = 0, passed = 0, total = 0, hi_cnt = 0, done_at = -1, d = 0;
  int t0 = 0, b_from = 0, b_to = 0, r_from = 0, r_to = 0;
  int done_edge = -1, set_edge = -1, clr_edge = -1;
  bit chk_en = 0, rv_exp = 0, wr_hold = 0;

  ising_run_ctrl #(.N(N), .SAMPLE_CYCLES(S), .SYNC_STAGES(SS)) dut (
    .clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort),
    .rst_cycles(rst_cycles), .run_cycles(run_cycles), .spin_in(spin_in),
    .wready_in(wready_in), .wready_out(wready_out), .wr_allow(wr_allow),
    .ising_rstn(ising_rstn), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // spin_in for edge cyc+1 comes from the plan of the current anneal
  always @(posedge clk) begin
    int k;
    cyc++;
    #1;
    k = cyc + 1 - t0;
    spin_in = (k >= 0 && k < plan.size()) ? plan[k] : N'($urandom);
    wready_in = wr_hold ? 1'b1 : 1'($urandom);
  end

  always @(negedge clk) if (chk_en) begin
    bit b_e, r_e;
    exp_t e;
    b_e = cyc >= b_from && cyc < b_to;
    r_e = cyc >= r_from && cyc < r_to;
    if (cyc == clr_edge) rv_exp = 0;
    if (cyc == set_edge) rv_exp = 1;
    chk("busy", 32'(busy), 32'(b_e));
    chk("wr_allow", 32'(wr_allow), 32'(!b_e));
    chk("wready_out", 32'(wready_out), 32'(wready_in & !b_e));
    chk("ising_rstn", 32'(ising_rstn), 32'(r_e));
    chk("result_valid", 32'(result_valid), 32'(rv_exp));
    chk("done", 32'(done), 32'(cyc == done_edge));
    if (ising_rstn) hi_cnt++;
    if (done) begin
      done_at = cyc;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL done: unexpected pulse at cycle %0d with nothing pending", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.at));
        chk("result", 32'(result), 32'(e.res));
        last_res = e.res;
      end
    end
  end

  // mode 0 random, 1 all spins equal, 2 spin1 anti-phase and spin2 in phase for m window cycles
  task automatic go(input int r, input int u, input int mode, input int m);
    int rr, uu, w0, c;
    logic [N-1:0] v;
    bit cb;
    exp_t e;
    rr = r < 1 ? 1 : r;
    uu = u < 1 ? 1 : u;
    w0 = rr + uu + 1 - SS;
    cb = 1'($urandom);
    plan.delete();
    for (int k = 0; k <= rr + uu + S; k++) begin
      v = N'($urandom);
      if (mode == 1) v = {N{cb}};
      if (mode == 2) begin
        v[1] = ~v[0];
        v[2] = (k - w0 < m) ? v[0] : ~v[0];
      end
      plan.push_back(v);
    end
    e.res = '0;
    for (int i = 0; i < N; i++) begin
      c = 0;
      for (int j = 0; j < S; j++) c += int'(plan[w0 + j][i] == plan[w0 + j][0]);
      e.res[i] = c > S / 2;
    end
    t0 = cyc + 1;
    e.at = t0 + rr + uu + S;
    b_from = t0; b_to = e.at;
    r_from = t0 + rr + 1; r_to = e.at + 1;
    done_edge = e.at; clr_edge = t0; set_edge = e.at;
    sb.push_back(e);
    rst_cycles = 16'(r);
    run_cycles = 32'(u);
    start = 1;
    step(1);
    start = 0;
  endtask

  task automatic finish_run();
    step(done_edge - cyc + 3);
  endtask

  task automatic do_abort(input bit with_start);
    exp_t e;
    abort = 1;
    start = with_start;
    if (done_edge > cyc) e = sb.pop_back();
    b_to = cyc + 1; r_to = cyc + 1;
    done_edge = -1; clr_edge = cyc + 1; set_edge = -1;
    step(1);
    abort = 0;
    start = 0;
  endtask

  initial begin
    step(3);
    chk("rst_ising_rstn", 32'(ising_rstn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_wr_allow", 32'(wr_allow), 1);
    axi_rst = 0;
    chk_en = 1;
    step(2);
    wr_hold = 1;
    hi_cnt = 0;
    go(3, 10, 1, 0);
    finish_run();
    wr_hold = 0;
    chk("rstn_high_cycles", 32'(hi_cnt), 41);
    chk("latency_3_10", 32'(done_at - t0), 44);
    chk("all_equal_result", 32'(result), 32'({N{1'b1}}));
    go(2, 5, 2, 16);
    finish_run();
    chk("anti_phase_bit", 32'(result[1]), 0);
    chk("vote_16_of_31", 32'(result[2]), 1);
    go(2, 5, 2, 15);
    finish_run();
    chk("vote_15_of_31", 32'(result[2]), 0);
    go(4, 20, 0, 0);
    step(8);
    rst_cycles = 1;
    run_cycles = 2;
    start = 1;
    step(1);
    start = 0;
    finish_run();
    chk("latency_ignored_start", 32'(done_at - t0), 55);
    go(0, 0, 0, 0);
    finish_run();
    chk("latency_0_0", 32'(done_at - t0), 33);
    go(3, 3, 0, 0);
    finish_run();
    go(1, 1, 0, 0);
    step(10);
    do_abort(1);
    step(40);
    chk("abort_result_held", 32'(result), 32'(last_res));
    chk("abort_no_valid", 32'(result_valid), 0);
    for (int n = 0; n < 10; n++) begin
      go($urandom_range(0, 6), $urandom_range(0, 12), 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom_range(1, done_edge - t0);
        if (d > 1) step(d - 1);
        do_abort(1'($urandom));
        step(3);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          step(3);
          run_cycles = 32'($urandom_range(0, 40));
          start = 1;
          step(1);
          start = 0;
        end
        finish_run();
      end
    end
    go(2, 20, 0, 0);
    step(6);
    chk_en = 0;
    #2 axi_rst = 1;
    #1;
    chk("midrun_rst_ising_rstn", 32'(ising_rstn), 0);
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_wr_allow", 32'(wr_allow), 1);
    chk("midrun_rst_result_valid", 32'(result_valid), 0);
    sb.delete();
    b_from = 0; b_to = 0; r_from = 0; r_to = 0;
    done_edge = -1; set_edge = -1; rv_exp = 0; last_res = 0;
    step(2);
    axi_rst = 0;
    chk_en = 1;
    step(3);
    chk("result_after_reset", 32'(result), 0);
    go(1, 2, 0, 0);
    finish_run();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
